// File: rtl/ami_port_merger.sv
// Merges the block-buffer read port (0) and writeback port (1) onto one AMI memory channel.
// Define AMI_MERGER_HAZARD_CHECK_EN to hold a read behind a pending writeback to the same 64 B block.
module ami_port_merger #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       reqIn_valid,
    input  logic [1:0]       reqIn_isWrite,
    input  logic [1:0][63:0] reqIn_addr,
    input  logic [1:0][63:0] reqIn_data,
    input  logic [1:0][7:0]  reqIn_size,
    output logic [1:0]       reqIn_grant,
    output logic [1:0]       respOut_valid,
    output logic [1:0][63:0] respOut_data,
    output logic [1:0][7:0]  respOut_size,
    input  logic [1:0]       respOut_grant,
    output logic             reqOut_valid,
    output logic             reqOut_isWrite,
    output logic [63:0]      reqOut_addr,
    output logic [63:0]      reqOut_data,
    output logic [7:0]       reqOut_size,
    input  logic             reqOut_grant,
    input  logic             respIn_valid,
    input  logic [63:0]      respIn_data,
    input  logic [7:0]       respIn_size,
    output logic             respIn_grant
);
    localparam logic [3:0] MAX_W = 4'(MAX_OUTSTANDING);

    logic [1:0]       slot_v_q, slot_v_d;
    logic [1:0]       slot_w_q, slot_w_d;
    logic [1:0][63:0] slot_addr_q, slot_addr_d;
    logic [1:0][63:0] slot_data_q, slot_data_d;
    logic [1:0][7:0]  slot_size_q, slot_size_d;
    logic             last_q, last_d;
    logic             lock_v_q, lock_v_d;
    logic             lock_sel_q, lock_sel_d;
    logic [3:0]       out_q, out_d;

    logic       hazard;
    logic [1:0] elig;
    logic [1:0] drain;
    logic       win_v;
    logic       win_sel;
    logic       rsp_dec;
    logic       unused_resp_grant1;

    assign unused_resp_grant1 = respOut_grant[1];

`ifdef AMI_MERGER_HAZARD_CHECK_EN
    assign hazard = slot_v_q[1] && (slot_addr_q[1][63:6] == slot_addr_q[0][63:6]);
`else
    assign hazard = 1'b0;
`endif

    // A stalled winner stays locked so the presented request cannot change under the memory.
    always_comb begin
        elig[1] = slot_v_q[1];
        elig[0] = slot_v_q[0] && (out_q < MAX_W) && !hazard;
        win_v   = 1'b0;
        win_sel = 1'b0;
        if (rst) begin
            win_v = 1'b0;
        end else if (lock_v_q) begin
            win_v   = 1'b1;
            win_sel = lock_sel_q;
        end else begin
            case (elig)
                2'b11: begin win_v = 1'b1; win_sel = ~last_q; end
                2'b10: begin win_v = 1'b1; win_sel = 1'b1;    end
                2'b01: begin win_v = 1'b1; win_sel = 1'b0;    end
                default: win_v = 1'b0;
            endcase
        end
    end

    assign reqOut_valid   = win_v;
    assign reqOut_isWrite = win_v ? slot_w_q[win_sel]    : 1'b0;
    assign reqOut_addr    = win_v ? slot_addr_q[win_sel] : 64'd0;
    assign reqOut_data    = win_v ? slot_data_q[win_sel] : 64'd0;
    assign reqOut_size    = win_v ? slot_size_q[win_sel] : 8'd0;

    assign drain[0] = win_v && reqOut_grant && !win_sel;
    assign drain[1] = win_v && reqOut_grant && win_sel;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            reqIn_grant[i] = !rst && reqIn_valid[i] && (!slot_v_q[i] || drain[i]);
            slot_v_d[i]    = reqIn_grant[i] || (slot_v_q[i] && !drain[i]);
            slot_w_d[i]    = reqIn_grant[i] ? reqIn_isWrite[i] : slot_w_q[i];
            slot_addr_d[i] = reqIn_grant[i] ? reqIn_addr[i]    : slot_addr_q[i];
            slot_data_d[i] = reqIn_grant[i] ? reqIn_data[i]    : slot_data_q[i];
            slot_size_d[i] = reqIn_grant[i] ? reqIn_size[i]    : slot_size_q[i];
        end
        last_d     = (win_v && reqOut_grant) ? win_sel : last_q;
        lock_v_d   = win_v && !reqOut_grant;
        lock_sel_d = win_sel;
    end

    // Responses with no credit outstanding are swallowed so stale traffic after reset drains.
    assign respOut_valid[0] = respIn_valid && (out_q != 4'd0);
    assign respOut_data[0]  = respIn_data;
    assign respOut_size[0]  = respIn_size;
    assign respOut_valid[1] = 1'b0;
    assign respOut_data[1]  = 64'd0;
    assign respOut_size[1]  = 8'd64;
    assign respIn_grant     = respOut_grant[0] || (respIn_valid && (out_q == 4'd0));

    always_comb begin
        rsp_dec = respIn_valid && respIn_grant && (out_q != 4'd0);
        out_d   = out_q;
        if (drain[0] && !rsp_dec) begin
            out_d = out_q + 4'd1;
        end else if (!drain[0] && rsp_dec) begin
            out_d = out_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_v_q   <= 2'b00;
            last_q     <= 1'b0;
            lock_v_q   <= 1'b0;
            lock_sel_q <= 1'b0;
            out_q      <= 4'd0;
        end else begin
            slot_v_q   <= slot_v_d;
            last_q     <= last_d;
            lock_v_q   <= lock_v_d;
            lock_sel_q <= lock_sel_d;
            out_q      <= out_d;
        end
    end

    always_ff @(posedge clk) begin
        slot_w_q    <= slot_w_d;
        slot_addr_q <= slot_addr_d;
        slot_data_q <= slot_data_d;
        slot_size_q <= slot_size_d;
    end
endmodule

// File: tb/tb_ami_port_merger.sv
// Bench for ami_port_merger: directed timing cases plus a randomized scoreboard run.
module tb_ami_port_merger;
    localparam int MAX = 4;
    localparam int N0 = 60;
    localparam int N1 = 40;
    localparam int LIMIT = 4000;
`ifdef AMI_MERGER_HAZARD_CHECK_EN
    localparam bit HAZ = 1'b1;
`else
    localparam bit HAZ = 1'b0;
`endif

    typedef struct packed {
        logic        w;
        logic [63:0] a;
        logic [63:0] d;
        logic [7:0]  s;
    } req_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       reqIn_valid, reqIn_isWrite, reqIn_grant;
    logic [1:0][63:0] reqIn_addr, reqIn_data;
    logic [1:0][7:0]  reqIn_size;
    logic [1:0]       respOut_valid, respOut_grant;
    logic [1:0][63:0] respOut_data;
    logic [1:0][7:0]  respOut_size;
    logic             reqOut_valid, reqOut_isWrite, reqOut_grant;
    logic [63:0]      reqOut_addr, reqOut_data;
    logic [7:0]       reqOut_size;
    logic             respIn_valid, respIn_grant;
    logic [63:0]      respIn_data;
    logic [7:0]       respIn_size;

    req_t        q0[$];
    req_t        q1[$];
    logic [63:0] exp_resp[$];
    int          n_checks = 0;
    int          n_fail = 0;
    bit          sb_en = 1'b0;
    int          model_out = 0;
    int          mem_pending = 0;

    always #5 clk = ~clk;

    ami_port_merger #(.MAX_OUTSTANDING(MAX)) dut (
        .clk(clk), .rst(rst),
        .reqIn_valid(reqIn_valid), .reqIn_isWrite(reqIn_isWrite), .reqIn_addr(reqIn_addr),
        .reqIn_data(reqIn_data), .reqIn_size(reqIn_size), .reqIn_grant(reqIn_grant),
        .respOut_valid(respOut_valid), .respOut_data(respOut_data), .respOut_size(respOut_size),
        .respOut_grant(respOut_grant),
        .reqOut_valid(reqOut_valid), .reqOut_isWrite(reqOut_isWrite), .reqOut_addr(reqOut_addr),
        .reqOut_data(reqOut_data), .reqOut_size(reqOut_size), .reqOut_grant(reqOut_grant),
        .respIn_valid(respIn_valid), .respIn_data(respIn_data), .respIn_size(respIn_size),
        .respIn_grant(respIn_grant)
    );

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle();
        reqIn_valid = '0; reqIn_isWrite = '0; reqIn_addr = '0; reqIn_data = '0; reqIn_size = '0;
        respOut_grant = '0; reqOut_grant = 1'b0;
        respIn_valid = 1'b0; respIn_data = '0; respIn_size = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic set_req(input int p, input logic w, input logic [63:0] a);
        reqIn_valid[p]   = 1'b1;
        reqIn_isWrite[p] = w;
        reqIn_addr[p]    = a;
        reqIn_data[p]    = a ^ 64'hDEAD_BEEF;
        reqIn_size[p]    = 8'd64;
    endtask

    task automatic issue_write(input logic [63:0] a);
        set_req(1, 1'b1, a);
        reqOut_grant = 1'b1;
        mid(); chk("wr_grant", reqIn_grant[1], 1'b1);
        step(); reqIn_valid = '0;
        mid(); chk("wr_out_addr", reqOut_addr, a); chk("wr_out_w", reqOut_isWrite, 1'b1);
        step(); idle();
    endtask

    // Read and write presented in the same cycle; wfirst says which must reach memory first.
    task automatic issue_pair(input logic [63:0] ra, input logic [63:0] wa, input logic wfirst);
        set_req(0, 1'b0, ra);
        set_req(1, 1'b1, wa);
        reqOut_grant = 1'b1;
        mid(); chk("pair_grant", reqIn_grant, 2'b11);
        step(); reqIn_valid = '0;
        mid(); chk("pair_first_w", reqOut_isWrite, wfirst); chk("pair_first_a", reqOut_addr, wfirst ? wa : ra);
        step();
        mid(); chk("pair_second_w", reqOut_isWrite, !wfirst); chk("pair_second_a", reqOut_addr, wfirst ? ra : wa);
        step(); reqOut_grant = 1'b0; respIn_valid = 1'b1; respIn_data = 64'h77; respOut_grant[0] = 1'b1;
        mid(); chk("pair_resp", respOut_valid[0], 1'b1);
        step(); idle();
    endtask

    // Scoreboard monitor: checks every memory-side and upstream-side handshake.
    req_t held;
    bit   held_v = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (!sb_en) begin
                held_v = 1'b0;
            end else begin
                if (held_v) begin
                    chk("hold_valid", reqOut_valid, 1'b1);
                    chk("hold_w", reqOut_isWrite, held.w);
                    chk("hold_addr", reqOut_addr, held.a);
                    chk("hold_data", reqOut_data, held.d);
                end
                held_v = reqOut_valid && !reqOut_grant;
                held   = '{w: reqOut_isWrite, a: reqOut_addr, d: reqOut_data, s: reqOut_size};
                if (reqOut_valid && reqOut_grant) begin
                    req_t e;
                    if (reqOut_isWrite) begin
                        chk("sb_q1_nonempty", q1.size() != 0, 1'b1);
                        if (q1.size() != 0) e = q1.pop_front();
                    end else begin
                        chk("sb_q0_nonempty", q0.size() != 0, 1'b1);
                        if (q0.size() != 0) e = q0.pop_front();
                        model_out++;
                        mem_pending++;
                        chk("credit_limit", model_out <= MAX, 1'b1);
                    end
                    chk("sb_addr", reqOut_addr, e.a);
                    chk("sb_data", reqOut_data, e.d);
                    chk("sb_size", reqOut_size, e.s);
                end
                if (respIn_valid && respIn_grant && model_out > 0) model_out--;
                if (respOut_valid[0] && respOut_grant[0]) begin
                    chk("resp_q_nonempty", exp_resp.size() != 0, 1'b1);
                    if (exp_resp.size() != 0) chk("resp_data", respOut_data[0], exp_resp.pop_front());
                end
            end
        end
    end

    initial begin
        int   n0, n1, cyc;
        bit   p0_busy, p1_busy, resp_busy, done;
        req_t cur0, cur1;

        // Reset state
        do_reset();
        mid();
        chk("rst_reqOut_valid", reqOut_valid, 1'b0);
        chk("rst_reqIn_grant", reqIn_grant, 2'b00);
        chk("rst_respIn_grant", respIn_grant, 1'b0);
        chk("rst_respOut_valid", respOut_valid, 2'b00);
        chk("resp1_size", respOut_size[1], 8'd64);
        step();

        // Single read and its response
        set_req(0, 1'b0, 64'h1000);
        reqOut_grant = 1'b1;
        mid(); chk("rd_grant", reqIn_grant[0], 1'b1); chk("rd_latency", reqOut_valid, 1'b0);
        step(); reqIn_valid = '0;
        mid(); chk("rd_out_valid", reqOut_valid, 1'b1); chk("rd_out_addr", reqOut_addr, 64'h1000);
        chk("rd_out_w", reqOut_isWrite, 1'b0);
        step(); reqOut_grant = 1'b0; respIn_valid = 1'b1; respIn_data = 64'hA5; respOut_grant[0] = 1'b1;
        mid(); chk("rd_resp_valid", respOut_valid[0], 1'b1); chk("rd_resp_data", respOut_data[0], 64'hA5);
        chk("rd_resp_grant", respIn_grant, 1'b1);
        step(); respIn_data = 64'h5A; respOut_grant[0] = 1'b0;
        mid(); chk("rd_credit_zero", respOut_valid[0], 1'b0); chk("rd_discard_grant", respIn_grant, 1'b1);
        step(); idle();

        // Ordering between ports
        do_reset();
        issue_pair(64'h2040, 64'h2000, 1'b1);
        issue_write(64'h3000);
        issue_pair(64'h2040, 64'h2000, 1'b0);
        issue_pair(64'h2010, 64'h2000, HAZ);

        // Credit limit
        do_reset();
        begin
            int issued = 0;
            reqOut_grant = 1'b1;
            for (int c = 0; c < 6; c++) begin
                reqIn_valid[0] = 1'b0;
                if (c < 5) set_req(0, 1'b0, 64'h4000 + 64'(c) * 64);
                mid();
                if (c < 5) chk("cr_accept", reqIn_grant[0], 1'b1);
                if (reqOut_valid && reqOut_grant) begin
                    chk("cr_addr", reqOut_addr, 64'h4000 + 64'(issued) * 64);
                    issued++;
                end
                step();
            end
            chk("cr_issued", issued, 4);
            reqIn_valid = '0;
            mid(); chk("cr_held", reqOut_valid, 1'b0);
            step(); respIn_valid = 1'b1; respIn_data = 64'h1; respOut_grant[0] = 1'b1;
            mid(); chk("cr_held_resp", reqOut_valid, 1'b0);
            step(); respIn_valid = 1'b0; respOut_grant[0] = 1'b0;
            mid(); chk("cr_fifth_valid", reqOut_valid, 1'b1); chk("cr_fifth_addr", reqOut_addr, 64'h4100);
            step(); idle();
        end

        // Memory stall with both slots full
        do_reset();
        set_req(0, 1'b0, 64'h5000);
        set_req(1, 1'b1, 64'h6000);
        mid(); chk("st_fill", reqIn_grant, 2'b11);
        step();
        set_req(0, 1'b0, 64'h5100);
        set_req(1, 1'b1, 64'h6100);
        for (int k = 0; k < 3; k++) begin
            mid();
            chk("st_valid", reqOut_valid, 1'b1);
            chk("st_w", reqOut_isWrite, 1'b1);
            chk("st_addr", reqOut_addr, 64'h6000);
            chk("st_data", reqOut_data, 64'h6000 ^ 64'hDEAD_BEEF);
            chk("st_no_accept", reqIn_grant, 2'b00);
            step();
        end
        reqOut_grant = 1'b1;
        mid(); chk("st_release_addr", reqOut_addr, 64'h6000); chk("st_reload", reqIn_grant, 2'b10);
        step(); reqIn_valid = '0;
        mid(); chk("st_rr_w", reqOut_isWrite, 1'b0); chk("st_rr_addr", reqOut_addr, 64'h5000);
        step(); idle();

        // Back-to-back reads at full rate
        do_reset();
        reqOut_grant = 1'b1;
        respOut_grant[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            set_req(0, 1'b0, 64'h7000 + 64'(c) * 64);
            respIn_valid = (c >= 2);
            respIn_data = 64'(c);
            mid();
            chk("tp_accept", reqIn_grant[0], 1'b1);
            if (c >= 1) begin
                chk("tp_valid", reqOut_valid, 1'b1);
                chk("tp_addr", reqOut_addr, 64'h7000 + 64'(c - 1) * 64);
            end
            if (c >= 2) chk("tp_resp", respOut_valid[0], 1'b1);
            step();
        end
        idle();

        // Reset with reads in flight
        do_reset();
        reqOut_grant = 1'b1;
        set_req(0, 1'b0, 64'h8000);
        step(); set_req(0, 1'b0, 64'h8040);
        step(); reqIn_valid = '0;
        mid(); chk("rm_second_issue", reqOut_addr, 64'h8040);
        step(); reqOut_grant = 1'b0; rst = 1'b1;
        step(); rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            respIn_valid = 1'b1;
            respIn_data = 64'(k);
            mid(); chk("rm_accept", respIn_grant, 1'b1); chk("rm_no_resp", respOut_valid[0], 1'b0);
            step();
        end
        idle();
        mid(); chk("rm_slots_clear", reqOut_valid, 1'b0);
        step();

        // Randomized traffic against the scoreboard
        do_reset();
        sb_en = 1'b1;
        model_out = 0; mem_pending = 0;
        n0 = 0; n1 = 0; cyc = 0;
        p0_busy = 1'b0; p1_busy = 1'b0; resp_busy = 1'b0; done = 1'b0;
        while (!done && cyc < LIMIT) begin
            if (!p0_busy) begin
                reqIn_valid[0] = 1'b0;
                if (n0 < N0 && $urandom_range(0, 2) != 0) begin
                    cur0 = '{w: 1'b0, a: {32'($urandom), 32'($urandom) & 32'hFFFF_FFC0},
                             d: {32'($urandom), 32'($urandom)}, s: 8'd64};
                    reqIn_valid[0] = 1'b1; reqIn_isWrite[0] = 1'b0;
                    reqIn_addr[0] = cur0.a; reqIn_data[0] = cur0.d; reqIn_size[0] = cur0.s;
                    p0_busy = 1'b1;
                end
            end
            if (!p1_busy) begin
                reqIn_valid[1] = 1'b0;
                if (n1 < N1 && $urandom_range(0, 2) == 0) begin
                    cur1 = '{w: 1'b1, a: {32'($urandom), 32'($urandom) & 32'hFFFF_FFC0},
                             d: {32'($urandom), 32'($urandom)}, s: 8'd64};
                    reqIn_valid[1] = 1'b1; reqIn_isWrite[1] = 1'b1;
                    reqIn_addr[1] = cur1.a; reqIn_data[1] = cur1.d; reqIn_size[1] = cur1.s;
                    p1_busy = 1'b1;
                end
            end
            if (!resp_busy) begin
                respIn_valid = 1'b0;
                if (mem_pending > 0 && $urandom_range(0, 1) == 1) begin
                    respIn_data = {32'($urandom), 32'($urandom)};
                    respIn_size = 8'd64;
                    respIn_valid = 1'b1;
                    exp_resp.push_back(respIn_data);
                    mem_pending--;
                    resp_busy = 1'b1;
                end
            end
            reqOut_grant = ($urandom_range(0, 3) != 0);
            respOut_grant[0] = ($urandom_range(0, 2) != 0);
            mid();
            if (reqIn_valid[0] && reqIn_grant[0]) begin q0.push_back(cur0); p0_busy = 1'b0; n0++; end
            if (reqIn_valid[1] && reqIn_grant[1]) begin q1.push_back(cur1); p1_busy = 1'b0; n1++; end
            if (respIn_valid && respIn_grant) resp_busy = 1'b0;
            step();
            cyc++;
            done = (n0 == N0) && (n1 == N1) && !p0_busy && !p1_busy && (q0.size() == 0) &&
                   (q1.size() == 0) && (mem_pending == 0) && !resp_busy && (exp_resp.size() == 0);
        end
        chk("rand_drained", done, 1'b1);
        sb_en = 1'b0;
        idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ami_port_merger.md
# ami_port_merger

Merges the two memory-side AMI ports of the block buffer (port 0 = block reads, port 1 = dirty-block writebacks) onto a single AMI request/response channel toward the memory system. Buffers one request per input port, arbitrates round-robin with a write-before-read ordering rule for the same 64 B block, and bounds in-flight reads with a credit counter. Read responses return to port 0. Port 1 never receives a response.

## Interface
Parameters:
- MAX_OUTSTANDING, 4: maximum granted-but-unanswered reads; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset; rst, synchronous, active-high; clock clk
- reqIn[1:0]  in  AMIRequest x2  upstream requests; [0] read port, [1] write port
- reqIn_grant[1:0]  out  1 x2  request accepted this cycle
- respOut[1:0]  out  AMIResponse x2  responses to upstream; [1] valid tied 0
- respOut_grant[1:0]  in  1 x2  upstream consumed response
- reqOut  out  AMIRequest  merged request to memory
- reqOut_grant  in  1  memory accepted reqOut this cycle
- respIn  in  AMIResponse  memory response (reads only)
- respIn_grant  out  1  response accepted

## Operation
- Per-port holding slot (slot_v[i], slot_req[i]), one entry each.
- reqIn_grant[i] = reqIn[i].valid && (!slot_v[i] || slot drained this cycle). Accepted request is written into the slot at the clock edge. Grant is combinational; no waiting on memory.
- Eligibility:
  - Slot 1 is eligible when slot_v[1].
  - Slot 0 is eligible when slot_v[0] && (outstanding < MAX_OUTSTANDING) && !hazard.
- Hazard, only with the macro (see Configuration): slot_v[1] && slot_req[1].addr[63:6] == slot_req[0].addr[63:6].
- Arbitration:
  - One eligible slot: it wins.
  - Both eligible: the slot not selected last time wins.
  - rr pointer `last` updates only when reqOut_grant is high.
- reqOut is the winner's slot contents with valid=1. With no winner, reqOut.valid=0 and the other fields are 0.
- The winning slot clears on reqOut_grant. If a new request is accepted on the same port in the same cycle, the slot reloads instead of clearing.
- outstanding counter, 4 bits:
  - +1 when a slot-0 read is granted.
  - -1 on respIn.valid && respIn_grant.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUTSTANDING, never underflows. A response arriving with outstanding==0 is accepted and discarded, and the counter stays 0.
- Response path is combinational:
  - respOut[0] = respIn with valid gated by (outstanding!=0).
  - respIn_grant = respOut_grant[0] || (respIn.valid && outstanding==0).
  - respOut[1] = '{valid:0, data:0, size:64}.
- Writes (isWrite=1) arriving on port 0, or reads arriving on port 1, are forwarded unchanged. No port check is performed.

## Timing
- Reset values:
  - slot_v = 0, last = 0 (port 1 wins first tie), outstanding = 0.
  - reqOut.valid = 0, reqIn_grant = 0, respIn_grant = 0, respOut[*].valid = 0.
- Latency: request granted in cycle N is presented on reqOut in cycle N+1 at the earliest.
- Throughput: one request per cycle per port while memory grants every cycle (slot drain + reload).
- reqOut holds stable while valid && !reqOut_grant. The winner does not switch while the memory stalls; arbitration is re-evaluated only after a grant.
- Counter at MAX_OUTSTANDING: slot 0 is ineligible the cycle the count reaches max. It becomes eligible the cycle after the decrementing response.
- rst mid-operation: all slots and the counter are dropped next edge. In-flight memory responses after reset are discarded via the outstanding==0 rule.

## Configuration
- AMI_MERGER_HAZARD_CHECK_EN defined: the same-block hazard blocks the slot-0 read while a slot-1 writeback to that block is pending. The writeback is issued first, so the read observes the written data.
- Not defined: hazard is constant 0 and arbitration is pure round-robin. The upstream block must then serialize writeback and refetch itself.

## Test plan
- Reset, then a single read addr 0x1000 on port 0 -> reqOut.valid at cycle+1 with addr 0x1000; memory response data 0xA5 -> respOut[0].valid with data 0xA5, outstanding back to 0.
- Read 0x2040 and write 0x2000 presented the same cycle, macro defined -> write (addr 0x2000) issued first, read second. Macro undefined -> port 1 first (reset tie) too; after a prior port-1 grant, the read goes first.
- MAX_OUTSTANDING=4, five back-to-back reads with no responses -> four reqOut grants, fifth held with reqOut.valid=0. One response -> fifth issued the following cycle.
- reqOut_grant held low for 3 cycles with both slots full -> reqOut fields constant across all 3 cycles, reqIn_grant low on both ports.
- Continuous reads with reqOut_grant=1 every cycle -> one reqOut per cycle, reqIn_grant[0] high every cycle.
- rst asserted while outstanding=2, then 2 responses arrive -> both accepted via respIn_grant, respOut[0].valid stays 0, counter stays 0.
